// File: rtl/spi_leader_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_leader_engine                                             |
// | Desc     : SPI leader with runtime length, CPOL/CPHA, bit order, divider |
// |            and NUM_CS active-low selects; valid/ready command, abort.    |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+

module spi_leader_engine #(
  parameter int DATA_W = 32,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic [$clog2(DATA_W)-1:0] len,
  input  logic [7:0]                cs_sel,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic                      lsb_first,
  input  logic [DIV_W-1:0]          div,
  input  logic                      abort,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  output logic                      cmd_err,
  output logic                      aborted,
  output logic                      busy,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso,
  output logic [NUM_CS-1:0]         cs_n
);

  localparam int LEN_W = $clog2(DATA_W);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_setup = 3'd1;
  localparam logic [2:0] c_st_shift = 3'd2;
  localparam logic [2:0] c_st_hold  = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  localparam logic [8:0] c_num_cs = 9'(NUM_CS);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [LEN_W:0]    r_edges;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_lsb;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_rx_valid;
  logic              r_cmd_err;
  logic              r_aborted;
  logic [NUM_CS-1:0] r_cs_n;
  logic [NUM_CS-1:0] w_cs_dec;

  logic              w_cs_ok;
  logic              w_tick;
  logic              w_last_edge;
  logic              w_leading;
  logic [LEN_W-1:0]  w_first_idx;
  logic [LEN_W-1:0]  w_idx_nxt;
  logic              w_start;
  logic              w_reject;
  logic              w_edge;
  logic              w_advance;
  logic              w_capture;
  logic              w_abort_now;
  logic              w_finish;

  assign w_cs_ok     = ({1'b0, cs_sel} < c_num_cs);
  assign w_tick      = (r_cnt == r_div);
  // r_edges counts edges already issued; the next one is the last when 2N-1 are done
  assign w_last_edge = (r_edges == {r_len, 1'b1});
  assign w_leading   = ~r_edges[0];
  assign w_first_idx = lsb_first ? '0 : len;
  assign w_idx_nxt   = r_lsb ? (r_idx + 1'b1) : (r_idx - 1'b1);

  for (genvar i = 0; i < NUM_CS; i++) begin : g_cs_dec
    localparam logic [7:0] c_idx = 8'(i);
    assign w_cs_dec[i] = (cs_sel == c_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (start_valid && w_cs_ok) w_state_nxt = c_st_setup;
      end
      c_st_setup, c_st_shift: begin
        if (abort)       w_state_nxt = c_st_idle;
        else if (w_tick) w_state_nxt = w_last_edge ? c_st_hold : c_st_shift;
      end
      c_st_hold: begin
        if (abort)       w_state_nxt = c_st_idle;
        else if (w_tick) w_state_nxt = c_st_done;
      end
      c_st_done: begin
        if (w_tick) w_state_nxt = c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b1;
    w_start     = 1'b0;
    w_reject    = 1'b0;
    w_edge      = 1'b0;
    w_advance   = 1'b0;
    w_capture   = 1'b0;
    w_abort_now = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      c_st_idle: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        w_start     = start_valid & w_cs_ok;
        w_reject    = start_valid & ~w_cs_ok;
      end
      c_st_setup, c_st_shift: begin
        w_abort_now = abort;
        w_edge      = w_tick & ~abort;
        // CPHA=1 shifts on leading edges after the first; CPHA=0 on trailing edges before the last
        w_advance   = w_edge & (r_cpha ? (w_leading & (r_edges != '0))
                                       : (~w_leading & ~w_last_edge));
        w_capture   = w_edge & (r_cpha ? ~w_leading : w_leading);
      end
      c_st_hold: begin
        w_abort_now = abort;
        w_finish    = w_tick & ~abort;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div      <= '0;
      r_edges    <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_aborted  <= 1'b0;
      r_cs_n     <= '1;
    end else begin
      r_rx_valid <= 1'b0;
      r_cmd_err  <= w_reject;
      r_aborted  <= w_abort_now;
      r_cnt      <= w_tick ? '0 : (r_cnt + 1'b1);
      if (w_start) begin
        r_cnt   <= '0;
        r_div   <= div;
        r_edges <= '0;
        r_len   <= len;
        r_idx   <= w_first_idx;
        r_cpol  <= cpol;
        r_cpha  <= cpha;
        r_lsb   <= lsb_first;
        r_tx    <= tx_data;
        r_rx    <= '0;
        r_sclk  <= cpol;
        r_mosi  <= tx_data[w_first_idx];
        r_cs_n  <= ~w_cs_dec;
      end
      if (w_edge) begin
        r_sclk  <= ~r_sclk;
        r_edges <= r_edges + 1'b1;
      end
      // miso is sampled on the same clk edge that flips sclk
      if (w_capture) r_rx[r_idx] <= miso;
      if (w_advance) begin
        r_idx  <= w_idx_nxt;
        r_mosi <= r_tx[w_idx_nxt];
      end
      if (w_finish) begin
        r_cs_n     <= '1;
        r_rx_data  <= r_rx;
        r_rx_valid <= 1'b1;
      end
      if (w_abort_now) begin
        r_cs_n <= '1;
        r_sclk <= r_cpol;
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign cmd_err  = r_cmd_err;
  assign aborted  = r_aborted;
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;
  assign cs_n     = r_cs_n;

endmodule

`default_nettype wire

// File: tb/tb_spi_leader_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spi_leader_engine                                          |
// | Desc     : Self-checking bench: directed cases plus random transfers     |
// |            against a behavioural SPI slave and timing reference.         |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+

module tb_spi_leader_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] tx_data;
  logic [4:0]  len;
  logic [7:0]  cs_sel;
  logic        cpol;
  logic        cpha;
  logic        lsb_first;
  logic [7:0]  div;
  logic        abort;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        cmd_err;
  logic        aborted;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [3:0]  cs_n;

  logic        loop_en    = 1'b1;
  logic        slave_miso = 1'b0;
  int          n_chk = 0;
  int          n_bad = 0;

  assign miso = loop_en ? mosi : slave_miso;

  always #5 clk = ~clk;

  spi_leader_engine #(.DATA_W(32), .NUM_CS(4), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .tx_data(tx_data), .len(len), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .div(div), .abort(abort), .rx_data(rx_data),
    .rx_valid(rx_valid), .cmd_err(cmd_err), .aborted(aborted), .busy(busy),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // position of the i-th transmitted bit inside the right-aligned word
  function automatic int bpos(input bit lsb, input int ln, input int i);
    return lsb ? i : (ln - i);
  endfunction

  // Full transfer with slave model and timing reference; hold keeps start_valid asserted.
  task automatic do_xfer(input logic [31:0] tx, input int ln, input int cs, input bit pol,
                         input bit pha, input bit lsb, input int dv, input bit loop,
                         input logic [31:0] sw, input bit hold);
    logic [31:0] mask, exp_rx, slv_rx;
    logic [3:0]  exp_cs;
    logic        prev_sclk;
    int h, n, j, edges, sidx, ridx, rv_t, rv_n, rdy_t, cs_low, bad_cs, bad_edge;
    h = dv + 1; n = ln + 1;
    mask   = 32'((64'd1 << n) - 64'd1);
    exp_rx = (loop ? tx : sw) & mask;
    exp_cs = ~(4'b0001 << cs);
    j = 0; edges = 0; sidx = 0; ridx = 0; rv_t = 0; rv_n = 0; rdy_t = 0;
    cs_low = 0; bad_cs = 0; bad_edge = 0; slv_rx = '0; prev_sclk = pol;
    loop_en = loop;
    start_valid = 1'b1; tx_data = tx; len = 5'(ln); cs_sel = 8'(cs);
    cpol = pol; cpha = pha; lsb_first = lsb; div = 8'(dv); abort = 1'b0;
    chk("ready_pre", start_ready, 1);
    @(posedge clk);
    while (rdy_t == 0 && j < 3000) begin
      @(negedge clk);
      j++;
      if (j == 1) begin
        if (!hold) begin
          start_valid = 1'b0; tx_data = $urandom; len = 5'($urandom); cs_sel = 8'($urandom);
          cpol = ~pol; cpha = ~pha; lsb_first = ~lsb; div = 8'($urandom);
        end
        chk("setup_cs", cs_n, exp_cs);
        chk("setup_sclk", sclk, pol);
        chk("first_mosi", mosi, tx[bpos(lsb, ln, 0)]);
        chk("busy", busy, 1);
        if (!pha) slave_miso = sw[bpos(lsb, ln, 0)];
      end
      if (sclk !== prev_sclk) begin
        edges++;
        prev_sclk = sclk;
        if (j != 1 + edges * h) bad_edge++;
        if (((edges % 2) == 0) == pha) begin
          if (ridx < n) slv_rx[bpos(lsb, ln, ridx)] = mosi;
          ridx++;
        end
        if (pha && (edges % 2) == 1) begin
          if (sidx < n) slave_miso = sw[bpos(lsb, ln, sidx)];
          sidx++;
        end
        if (!pha && (edges % 2) == 0 && edges < 2 * n) begin
          sidx++;
          if (sidx < n) slave_miso = sw[bpos(lsb, ln, sidx)];
        end
      end
      if (cs_n !== 4'hF) begin
        cs_low++;
        if (cs_n !== exp_cs) bad_cs++;
      end
      if (rx_valid === 1'b1) begin
        rv_n++;
        rv_t = j;
        chk("rx_data", rx_data, exp_rx);
        chk("done_sclk", sclk, pol);
      end
      if (j > 1 && start_ready === 1'b1) rdy_t = j;
    end
    chk("timeout", rdy_t != 0, 1);
    chk("edges", edges, 2 * n);
    chk("edge_timing", bad_edge, 0);
    chk("cs_low_cycles", cs_low, (2 * n + 1) * h);
    chk("cs_other", bad_cs, 0);
    chk("rx_valid_time", rv_t, 1 + (2 * n + 1) * h);
    chk("rx_valid_count", rv_n, 1);
    chk("ready_time", rdy_t, 1 + (2 * n + 2) * h);
    chk("mosi_stream", slv_rx, tx & mask);
  endtask

  task automatic launch(input logic [31:0] tx, input int ln, input bit pol, input int dv);
    loop_en = 1'b1;
    start_valid = 1'b1; tx_data = tx; len = 5'(ln); cs_sel = 8'd1;
    cpol = pol; cpha = 1'b0; lsb_first = 1'b0; div = 8'(dv); abort = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic wait_edges(input int k, input logic pol);
    int e = 0;
    int t = 0;
    logic p = pol;
    while (e < k && t < 500) begin
      @(negedge clk);
      t++;
      if (sclk !== p) begin
        e++;
        p = sclk;
      end
    end
    chk("edge_wait", e, k);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] old_rx;
    int          cnt;
    rst = 1'b1; start_valid = 1'b0; tx_data = '0; len = '0; cs_sel = '0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; div = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_pulses", {rx_valid, cmd_err, aborted}, 0);
    chk("rst_sclk_mosi", {sclk, mosi}, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    rst = 1'b0;
    @(negedge clk);

    // basic 8-bit loopback, fastest clock
    do_xfer(32'hA5, 7, 0, 0, 0, 0, 0, 1, 32'h0, 0);
    // all four modes against an independent slave word
    for (int m = 0; m < 4; m++)
      do_xfer(32'h1234, 15, 1, m[1], m[0], 0, 3, 0, 32'hBEEF, 0);
    // full-width LSB-first and single-bit transfers
    do_xfer(32'h8000_0001, 31, 3, 0, 0, 1, 1, 1, 32'h0, 0);
    do_xfer(32'h1, 0, 0, 1, 1, 0, 0, 1, 32'h0, 0);
    do_xfer(32'h3C, 7, 2, 0, 1, 0, 0, 1, 32'h0, 0);

    // out-of-range chip select is rejected
    start_valid = 1'b1; cs_sel = 8'd5; len = 5'd7; div = 8'd0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    chk("cmd_err_pulse", cmd_err, 1);
    chk("cmd_err_cs", cs_n, 4'hF);
    chk("cmd_err_ready", {start_ready, busy}, 2'b10);
    @(negedge clk);
    chk("cmd_err_clear", cmd_err, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_valid !== 1'b0 || cs_n !== 4'hF) cnt++;
    end
    chk("cmd_err_quiet", cnt, 0);

    // abort after the 5th sclk edge
    old_rx = rx_data;
    launch(32'hFFFF_0000, 15, 1, 1);
    wait_edges(5, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_cs", cs_n, 4'hF);
    chk("abort_sclk", sclk, 1);
    chk("abort_pulse", aborted, 1);
    chk("abort_no_valid", rx_valid, 0);
    chk("abort_ready", start_ready, 1);
    chk("abort_rx_kept", rx_data, old_rx);
    @(negedge clk);
    chk("abort_pulse_end", aborted, 0);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_valid !== 1'b0 || busy !== 1'b0) cnt++;
    end
    chk("abort_quiet", cnt, 0);

    // reset in the middle of shifting
    launch(32'hFFFF_FFFF, 31, 0, 2);
    wait_edges(6, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cs", cs_n, 4'hF);
    chk("mid_rst_sclk_mosi", {sclk, mosi}, 0);
    chk("mid_rst_rx", rx_data, 0);
    chk("mid_rst_pulses", {rx_valid, aborted, cmd_err}, 0);
    chk("mid_rst_ready", {start_ready, busy}, 2'b10);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_valid !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) cnt++;
    end
    chk("mid_rst_quiet", cnt, 0);

    // back-to-back commands with start_valid held
    do_xfer(32'h5A, 7, 3, 0, 0, 1, 2, 1, 32'h0, 1);
    do_xfer(32'hC3, 7, 0, 1, 0, 0, 2, 0, 32'h96, 0);

    // random transfers, some issued back-to-back
    for (int k = 0; k < 24; k++)
      do_xfer($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
              1'($urandom), $urandom, (k < 23) ? 1'($urandom) : 1'b0);
    start_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
